// File: rtl/memory_port_arbiter_if.sv
// Bundle shared by the fetch unit, the load/store unit, the data RAM and the IO register.
// The arbiter takes the slave side; requesters and the RAM sit on the master side.
interface memory_port_arbiter_if #(
  parameter int unsigned MEM_WORDS = 1024
);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ack;
  logic [31:0]   fetch_rdata;
  logic          fetch_error;

  logic          data_req;
  logic          data_we;
  logic [3:0]    data_byte_en;
  logic [31:0]   data_addr;
  logic [31:0]   data_wdata;
  logic          data_ack;
  logic [31:0]   data_rdata;
  logic          data_error;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [7:0]    memory_mapped_io;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_ack, fetch_rdata, fetch_error,
    input  data_req, data_we, data_byte_en, data_addr, data_wdata,
    output data_ack, data_rdata, data_error,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output memory_mapped_io
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_ack, fetch_rdata, fetch_error,
    output data_req, data_we, data_byte_en, data_addr, data_wdata,
    input  data_ack, data_rdata, data_error,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  memory_mapped_io
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch and load/store,
// and decodes the byte-wide memory-mapped IO register.
module memory_port_arbiter #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] IO_ADDR   = 32'h2000
) (
  input logic                  clk,
  input logic                  reset_n,
  memory_port_arbiter_if.slave bus
);
  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_F = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_grant_data;
  logic          r_f_err;
  logic          r_d_err;
  logic          r_d_ram;
  logic [31:0]   r_d_val;
  logic [7:0]    r_io;

  logic          w_f_elig;
  logic          w_d_elig;
  logic          w_grant_f;
  logic          w_grant_d;
  logic          w_f_err;
  logic          w_d_io;
  logic          w_d_err;
  logic          w_d_ram;
  logic          w_mem_en;
  logic [3:0]    w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_wdata;
  logic          w_f_ack;
  logic          w_d_ack;

  // Address decode: IO takes priority over the out-of-range check.
  assign w_f_err = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr >= MEM_BYTES);
  assign w_d_io  = (bus.data_addr == IO_ADDR);
  assign w_d_err = !w_d_io && (bus.data_addr >= MEM_BYTES);
  assign w_d_ram = !w_d_io && !w_d_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant selection; the requester being acknowledged this cycle sits out.
  always_comb begin
    w_state_nxt = IDLE;
    w_grant_f   = 1'b0;
    w_grant_d   = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 4'h0;
    w_mem_addr  = '0;
    w_mem_wdata = 32'h0;
    w_f_elig    = reset_n && bus.fetch_req && (r_state != RESP_F);
    w_d_elig    = reset_n && bus.data_req && (r_state != RESP_D);

    if (w_d_elig && (!w_f_elig || !r_last_grant_data)) begin
      w_grant_d = 1'b1;
    end else if (w_f_elig) begin
      w_grant_f = 1'b1;
    end

    if (w_grant_d) begin
      w_state_nxt = RESP_D;
      w_mem_en    = w_d_ram;
      w_mem_addr  = bus.data_addr[AW+1:2];
      w_mem_wdata = bus.data_wdata;
      if (w_d_ram && bus.data_we) begin
        w_mem_we = bus.data_byte_en;
      end
    end else if (w_grant_f) begin
      w_state_nxt = RESP_F;
      w_mem_en    = !w_f_err;
      w_mem_addr  = bus.fetch_addr[AW+1:2];
    end
  end

  // Response bookkeeping captured in the grant cycle, plus the IO register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_grant_data <= 1'b0;
      r_f_err           <= 1'b0;
      r_d_err           <= 1'b0;
      r_d_ram           <= 1'b0;
      r_d_val           <= 32'h0;
      r_io              <= 8'h00;
    end else if (w_grant_d) begin
      r_last_grant_data <= 1'b1;
      r_d_err           <= w_d_err;
      r_d_ram           <= w_d_ram;
      r_d_val           <= (w_d_io && !bus.data_we) ? {24'h0, r_io} : 32'h0;
      if (w_d_io && bus.data_we && bus.data_byte_en[0]) begin
        r_io <= bus.data_wdata[7:0];
      end
    end else if (w_grant_f) begin
      r_last_grant_data <= 1'b0;
      r_f_err           <= w_f_err;
    end
  end

  // Acks are gated by reset so a reset landing in a response cycle drops it.
  assign w_f_ack = reset_n && (r_state == RESP_F);
  assign w_d_ack = reset_n && (r_state == RESP_D);

  assign bus.fetch_ack        = w_f_ack;
  assign bus.fetch_error      = w_f_ack && r_f_err;
  assign bus.fetch_rdata      = (w_f_ack && !r_f_err) ? bus.mem_rdata : 32'h0;
  assign bus.data_ack         = w_d_ack;
  assign bus.data_error       = w_d_ack && r_d_err;
  assign bus.data_rdata       = w_d_ack ? (r_d_ram ? bus.mem_rdata : r_d_val) : 32'h0;
  assign bus.mem_en           = w_mem_en;
  assign bus.mem_we           = w_mem_we;
  assign bus.mem_addr         = w_mem_addr;
  assign bus.mem_wdata        = w_mem_wdata;
  assign bus.memory_mapped_io = r_io;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: vector table, scoreboard queue,
// and hand-written contention and reset sequences.
module tb_memory_port_arbiter;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned AW        = $clog2(MEM_WORDS);

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  memory_port_arbiter_if #(.MEM_WORDS(MEM_WORDS)) bus ();

  memory_port_arbiter #(.MEM_WORDS(MEM_WORDS), .IO_ADDR(32'h2000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous write-first RAM
  logic [31:0] ram [MEM_WORDS];
  logic [31:0] ram_w;
  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] = 32'h0;
    bus.mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (bus.mem_en) begin
      ram_w = ram[bus.mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) ram_w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
      ram[bus.mem_addr] <= ram_w;
      bus.mem_rdata     <= ram_w;
    end
  end

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } exp_t;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mem_en;
    logic [3:0]  exp_mem_we;
    logic [7:0]  exp_io;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [17];
  vec_t v_tmp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (bus.fetch_ack || bus.data_ack) begin
      check("single_ack", 32'(bus.fetch_ack & bus.data_ack), 32'h0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got fetch_ack %b data_ack %b expected none",
                 bus.fetch_ack, bus.data_ack);
      end else begin
        mon_e = sb_q.pop_front();
        check("ack_src", 32'(bus.data_ack), 32'(mon_e.is_data));
        if (mon_e.is_data) begin
          check("data_error", 32'(bus.data_error), 32'(mon_e.err));
          if (mon_e.chk_rd) check("data_rdata", bus.data_rdata, mon_e.rdata);
        end else begin
          check("fetch_error", 32'(bus.fetch_error), 32'(mon_e.err));
          if (mon_e.chk_rd) check("fetch_rdata", bus.fetch_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.fetch_req    = 1'b0;
    bus.fetch_addr   = 32'h0;
    bus.data_req     = 1'b0;
    bus.data_we      = 1'b0;
    bus.data_byte_en = 4'h0;
    bus.data_addr    = 32'h0;
    bus.data_wdata   = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    if (v.is_data) begin
      bus.data_req     = 1'b1;
      bus.data_we      = v.we;
      bus.data_byte_en = v.be;
      bus.data_addr    = v.addr;
      bus.data_wdata   = v.wdata;
    end else begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = v.addr;
    end
    sb_q.push_back('{is_data: v.is_data, rdata: v.exp_rdata, err: v.exp_err, chk_rd: v.chk_rd});
    @(negedge clk);
    check("grant_mem_en", 32'(bus.mem_en), 32'(v.exp_mem_en));
    check("grant_mem_we", 32'(bus.mem_we), 32'(v.exp_mem_we));
    if (v.exp_mem_en) check("grant_mem_addr", 32'(bus.mem_addr), 32'(v.addr[AW+1:2]));
    @(negedge clk);
    check("ack_latency", 32'(v.is_data ? bus.data_ack : bus.fetch_ack), 32'h1);
    check("resp_mem_en", 32'(bus.mem_en), 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("io_reg", 32'(bus.memory_mapped_io), 32'(v.exp_io));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            d  we be     addr         wdata         chk rdata         err en we    io
    vecs[0]  = '{1, 1, 4'hF, 32'h0000_00FC, 32'hFEDCBA98, 0, 32'h0,        0, 1, 4'hF, 8'h00};
    vecs[1]  = '{1, 0, 4'h0, 32'h0000_00FC, 32'h0,        1, 32'hFEDCBA98, 0, 1, 4'h0, 8'h00};
    vecs[2]  = '{1, 1, 4'h4, 32'h0000_00FC, 32'h00320000, 0, 32'h0,        0, 1, 4'h4, 8'h00};
    vecs[3]  = '{1, 0, 4'h0, 32'h0000_00FC, 32'h0,        1, 32'hFE32BA98, 0, 1, 4'h0, 8'h00};
    vecs[4]  = '{1, 1, 4'h1, 32'h0000_2000, 32'h000000D1, 0, 32'h0,        0, 0, 4'h0, 8'hD1};
    vecs[5]  = '{1, 0, 4'h0, 32'h0000_2000, 32'h0,        1, 32'h000000D1, 0, 0, 4'h0, 8'hD1};
    vecs[6]  = '{1, 1, 4'h0, 32'h0000_2000, 32'h00000077, 0, 32'h0,        0, 0, 4'h0, 8'hD1};
    vecs[7]  = '{1, 0, 4'h0, 32'h0000_2000, 32'h0,        1, 32'h000000D1, 0, 0, 4'h0, 8'hD1};
    vecs[8]  = '{0, 0, 4'h0, 32'h0000_0102, 32'h0,        1, 32'h0,        1, 0, 4'h0, 8'hD1};
    vecs[9]  = '{1, 0, 4'h0, 32'h0000_1000, 32'h0,        1, 32'h0,        1, 0, 4'h0, 8'hD1};
    vecs[10] = '{1, 1, 4'hF, 32'h0000_0040, 32'hA5A5A5A5, 0, 32'h0,        0, 1, 4'hF, 8'hD1};
    vecs[11] = '{1, 1, 4'h0, 32'h0000_0040, 32'h12345678, 0, 32'h0,        0, 1, 4'h0, 8'hD1};
    vecs[12] = '{1, 0, 4'h0, 32'h0000_0040, 32'h0,        1, 32'hA5A5A5A5, 0, 1, 4'h0, 8'hD1};
    vecs[13] = '{0, 0, 4'h0, 32'h0000_00FC, 32'h0,        1, 32'hFE32BA98, 0, 1, 4'h0, 8'hD1};
    vecs[14] = '{0, 0, 4'h0, 32'h0000_1000, 32'h0,        1, 32'h0,        1, 0, 4'h0, 8'hD1};
    vecs[15] = '{1, 1, 4'hF, 32'h0000_2004, 32'h00000055, 1, 32'h0,        1, 0, 4'h0, 8'hD1};
    vecs[16] = '{0, 0, 4'h0, 32'h0000_0008, 32'h0,        1, 32'h0,        0, 1, 4'h0, 8'hD1};

    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fetch_ack",   32'(bus.fetch_ack),        32'h0);
    check("rst_data_ack",    32'(bus.data_ack),         32'h0);
    check("rst_fetch_error", 32'(bus.fetch_error),      32'h0);
    check("rst_data_error",  32'(bus.data_error),       32'h0);
    check("rst_io",          32'(bus.memory_mapped_io), 32'h0);
    check("rst_mem_en",      32'(bus.mem_en),           32'h0);
    check("rst_mem_we",      32'(bus.mem_we),           32'h0);
    check("rst_fetch_rdata", bus.fetch_rdata,           32'h0);
    check("rst_data_rdata",  bus.data_rdata,            32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Contention from reset: grants must alternate D,F,... with the RAM busy every cycle.
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n        = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0000_00FC;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b0;
    bus.data_addr  = 32'h0000_0040;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back('{is_data: 1'b1, rdata: 32'hA5A5A5A5, err: 1'b0, chk_rd: 1'b1});
      sb_q.push_back('{is_data: 1'b0, rdata: 32'hFE32BA98, err: 1'b0, chk_rd: 1'b1});
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("cont_mem_en", 32'(bus.mem_en), 32'h1);
      check("cont_order", 32'(bus.mem_addr), (c % 2 == 0) ? 32'd16 : 32'd63);
      if (c > 0) check("cont_one_ack", 32'(bus.fetch_ack ^ bus.data_ack), 32'h1);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("cont_last_ack", 32'(bus.fetch_ack), 32'h1);
    @(negedge clk);
    check("cont_quiet", 32'(bus.fetch_ack | bus.data_ack), 32'h0);

    // Reset landing in the response cycle of a store.
    v_tmp = '{1, 1, 4'h1, 32'h0000_2000, 32'h0000005A, 0, 32'h0, 0, 0, 4'h0, 8'h5A};
    run_vec(v_tmp);
    @(posedge clk); #1;
    bus.data_req     = 1'b1;
    bus.data_we      = 1'b1;
    bus.data_byte_en = 4'hF;
    bus.data_addr    = 32'h0000_0080;
    bus.data_wdata   = 32'hCAFEF00D;
    @(negedge clk);
    check("rstresp_mem_en", 32'(bus.mem_en), 32'h1);
    check("rstresp_mem_we", 32'(bus.mem_we), 32'hF);
    @(posedge clk); #1;
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rstresp_no_ack", 32'(bus.data_ack), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rstresp_io_clear", 32'(bus.memory_mapped_io), 32'h0);
    v_tmp = '{1, 0, 4'h0, 32'h0000_0080, 32'h0, 1, 32'hCAFEF00D, 0, 1, 4'h0, 8'h00};
    run_vec(v_tmp);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
